// File: rtl/unsat_clause_picker_pkg.sv
// Shared constants and tree-indexing helpers for the unsat_clause_picker tournament tree.
// Nodes are numbered breadth-first: leaf-level nodes first, the root last.
package unsat_clause_picker_pkg;

    localparam int LFSR_WIDTH = 16;

    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback taps on state bits 15, 13, 12, 10.
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED     = 16'hACE1;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAP_MASK = 16'hB400;

    // Global number of the first node on tree level lvl for an n-clause tree.
    function automatic int level_base(input int lvl, input int n);
        return n - (n >> lvl);
    endfunction

    // Tree level that node k belongs to.
    function automatic int node_level(input int k, input int n);
        int lvl;
        lvl = 0;
        for (int l = 1; l <= 5; l++) begin
            if (k >= level_base(l, n)) lvl = l;
        end
        return lvl;
    endfunction

    // Lower-indexed child of a non-leaf node k; the other child is the next node.
    function automatic int node_child(input int k, input int n);
        int lvl;
        lvl = node_level(k, n);
        return level_base(lvl - 1, n) + 2 * (k - level_base(lvl, n));
    endfunction

endpackage

// File: rtl/unsat_clause_picker_pair_select.sv
// clause_pair_select: one combinational tournament node; an unsatisfied input beats a
// satisfied one, and equal inputs are resolved by the tie bit (0 = lower, 1 = higher).
module clause_pair_select
    import unsat_clause_picker_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] lo_idx,
    input  logic         lo_sat,
    input  logic [W-1:0] hi_idx,
    input  logic         hi_sat,
    input  logic         tie_hi,
    output logic [W-1:0] win_idx,
    output logic         win_sat
);

    logic pick_hi;

    always_comb begin
        // NOTE: both branches assign pick_hi, so this stays purely combinational (no latch).
        if (lo_sat != hi_sat) begin
            pick_hi = lo_sat;
        end else begin
            pick_hi = tie_hi;
        end
    end

    assign win_idx = pick_hi ? hi_idx : lo_idx;
    assign win_sat = lo_sat & hi_sat;

endmodule

// File: rtl/unsat_clause_picker.sv
// Pipelined tournament tree selecting an unsatisfied clause index, one result per cycle.
// Optional RANDOM_TIEBREAK_EN: ties are broken by a 16-bit LFSR instead of lowest-index-wins.
module unsat_clause_picker
    import unsat_clause_picker_pkg::*;
#(
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 3
) (
    input  logic                                          in_clk,
    input  logic                                          in_reset_n,
    input  logic                                          in_valid,
    output logic                                          out_ready,
    input  logic [(1 << MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] in_clauses_satisfied,
    input  logic                                          in_flush,
    output logic                                          out_valid,
    input  logic                                          in_ready,
    output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
    output logic                                          out_clause_satisfied
);

    localparam int W = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam int N = 1 << W;

    logic                  stall;
    logic [W-1:0]          vld_d, vld_q;
    logic [N-2:0][W-1:0]   sel_idx, node_idx_d, node_idx_q;
    logic [N-2:0]          sel_sat, node_sat_d, node_sat_q;
    logic [N-2:0]          tie;

    assign stall     = vld_q[W-1] && !in_ready;
    assign out_ready = !stall;

    // Tree nodes: leaves read the input flags, inner nodes read their children's registers.
    for (genvar k = 0; k < N - 1; k++) begin : g_node
        localparam int LVL = node_level(k, N);

        logic [W-1:0] a_idx, b_idx;
        logic         a_sat, b_sat;

        if (LVL == 0) begin : g_leaf
            assign a_idx = W'(2 * k);
            assign b_idx = W'(2 * k + 1);
            assign a_sat = in_clauses_satisfied[2 * k];
            assign b_sat = in_clauses_satisfied[2 * k + 1];
        end else begin : g_inner
            localparam int CH = node_child(k, N);
            assign a_idx = node_idx_q[CH];
            assign b_idx = node_idx_q[CH + 1];
            assign a_sat = node_sat_q[CH];
            assign b_sat = node_sat_q[CH + 1];
        end

        clause_pair_select #(.W(W)) u_sel (
            .lo_idx  (a_idx),
            .lo_sat  (a_sat),
            .hi_idx  (b_idx),
            .hi_sat  (b_sat),
            .tie_hi  (tie[k]),
            .win_idx (sel_idx[k]),
            .win_sat (sel_sat[k])
        );
    end

`ifdef RANDOM_TIEBREAK_EN
    logic [LFSR_WIDTH-1:0] lfsr_d, lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (in_valid && out_ready && !in_flush) begin
            lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAP_MASK)};
        end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Tie bits are sampled at accept and delayed so each travels alongside its own data.
    for (genvar k = 0; k < N - 1; k++) begin : g_tie
        localparam int LVL = node_level(k, N);

        if (LVL == 0) begin : g_now
            assign tie[k] = lfsr_q[k];
        end else begin : g_delay
            logic [LVL-1:0] chain_d, chain_q;

            always_comb begin
                chain_d = chain_q;
                if (!stall) begin
                    chain_d[0] = lfsr_q[k];
                    for (int s = 1; s < LVL; s++) chain_d[s] = chain_q[s-1];
                end
            end

            always_ff @(posedge in_clk or negedge in_reset_n) begin
                if (!in_reset_n) begin
                    chain_q <= '0;
                end else begin
                    chain_q <= chain_d;
                end
            end

            assign tie[k] = chain_q[LVL-1];
        end
    end
`else
    assign tie = '0;
`endif

    always_comb begin
        vld_d      = vld_q;
        node_idx_d = node_idx_q;
        node_sat_d = node_sat_q;
        if (!stall) begin
            node_idx_d = sel_idx;
            node_sat_d = sel_sat;
            vld_d[0]   = in_valid;
            for (int l = 1; l < W; l++) vld_d[l] = vld_q[l-1];
        end
        // Flush wins over both an accept and a stall.
        if (in_flush) vld_d = '0;
    end

    // NOTE: pipeline data registers are reset as well so the outputs read zero during reset.
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            vld_q      <= '0;
            node_idx_q <= '0;
            node_sat_q <= '0;
        end else begin
            // NOTE: non-blocking, so every stage samples its predecessor's pre-edge value.
            vld_q      <= vld_d;
            node_idx_q <= node_idx_d;
            node_sat_q <= node_sat_d;
        end
    end

    assign out_valid            = vld_q[W-1];
    assign out_clause_index     = node_idx_q[N-2];
    assign out_clause_satisfied = node_sat_q[N-2];

endmodule
